// File: rtl/inv_mon_pkg.sv
// Shared types and elaboration helpers for the inverter-chain delay monitor.
`timescale 1ns/1ps
package inv_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_LAUNCH,
    ST_COUNT,
    ST_ACCUM,
    ST_DONE
  } mon_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Accumulator width: one per-sample count plus headroom for N_SAMPLES adds.
  function automatic int sum_width(input int cnt_w, input int n_samples);
    return cnt_w + clog2(n_samples);
  endfunction

endpackage

// File: rtl/inv_mon_sync.sv
// Multi-flop synchronizer bringing the asynchronous chain far end into clk.
`timescale 1ns/1ps
module inv_mon_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rn,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rn) begin
    if (!i_rn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/inv_chain_delay_monitor.sv
// Launches edges into an external inverter chain, times their arrival and averages N_SAMPLES.
// Optional MIN_DLY/MAX_DLY outputs are built when MON_MINMAX_EN is defined.
`timescale 1ns/1ps
module inv_chain_delay_monitor
  import inv_mon_pkg::*;
#(
  parameter int CNT_W       = 12,
  parameter int N_SAMPLES   = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CHAIN_INV   = 1,
  parameter int TIMEOUT     = 4095
) (
  input  logic             i_clk,
  input  logic             i_rn,
  inout  wire              io_vdd,
  inout  wire              io_vss,
  input  logic             i_start,
  input  logic             i_ret,
  output logic             o_launch,
  output logic             o_busy,
  output logic             o_valid,
  output logic             o_err,
  output logic [CNT_W-1:0] o_result
`ifdef MON_MINMAX_EN
  ,
  output logic [CNT_W-1:0] o_min_dly,
  output logic [CNT_W-1:0] o_max_dly
`endif
);

  localparam int LOG2N = clog2(N_SAMPLES);
  localparam int SUM_W = sum_width(CNT_W, N_SAMPLES);
  localparam int IDX_W = (LOG2N < 1) ? 1 : LOG2N;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  localparam logic L_INV = (CHAIN_INV != 0);

  mon_state_t       r_state;
  logic             r_launch;
  logic             r_busy;
  logic             r_valid;
  logic             r_err;
  logic [CNT_W-1:0] r_result;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_sample;
  logic [SUM_W-1:0] r_sum;
  logic [IDX_W-1:0] r_idx;

  logic             w_ret_s;
  logic             w_match;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [SUM_W-1:0] w_sum_new;
  logic [CNT_W-1:0] w_avg;
  wire              w_unused_pwr = io_vdd ^ io_vss;

  inv_mon_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk(i_clk),
    .i_rn (i_rn),
    .i_d  (i_ret),
    .o_q  (w_ret_s)
  );

  // Chain has settled when the synchronized far end equals the launch level through the chain.
  assign w_match   = (w_ret_s == (r_launch ^ L_INV));
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_sum_new = r_sum + SUM_W'(r_sample);
  assign w_avg     = CNT_W'(w_sum_new >> LOG2N);

  always_ff @(posedge i_clk or negedge i_rn) begin
    if (!i_rn) begin
      r_state  <= ST_IDLE;
      r_launch <= 1'b0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
      r_cnt    <= '0;
      r_sample <= '0;
      r_sum    <= '0;
      r_idx    <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_ARM;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
          end
        end
        ST_ARM: begin
          if (w_match) begin
            r_state <= ST_LAUNCH;
          end else if (w_cnt_inc == TMO) begin
            r_state <= ST_DONE;
            r_err   <= 1'b1;
            r_valid <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        ST_LAUNCH: begin
          r_launch <= ~r_launch;
          r_cnt    <= '0;
          r_state  <= ST_COUNT;
        end
        ST_COUNT: begin
          // r_cnt holds the edges elapsed since the toggle, so a loopback reads SYNC_STAGES.
          if (w_match) begin
            r_sample <= r_cnt;
            r_state  <= ST_ACCUM;
          end else if (w_cnt_inc == TMO) begin
            r_state <= ST_DONE;
            r_err   <= 1'b1;
            r_valid <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        ST_ACCUM: begin
          r_sum <= w_sum_new;
          if (r_idx == LAST_IDX) begin
            r_state  <= ST_DONE;
            r_valid  <= 1'b1;
            r_result <= w_avg;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_cnt   <= '0;
            r_state <= ST_ARM;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_launch = r_launch;
  assign o_busy   = r_busy;
  assign o_valid  = r_valid;
  assign o_err    = r_err;
  assign o_result = r_result;

`ifdef MON_MINMAX_EN
  logic [CNT_W-1:0] r_min;
  logic [CNT_W-1:0] r_max;
  logic [CNT_W-1:0] r_min_dly;
  logic [CNT_W-1:0] r_max_dly;
  logic [CNT_W-1:0] w_min_new;
  logic [CNT_W-1:0] w_max_new;

  assign w_min_new = (r_sample < r_min) ? r_sample : r_min;
  assign w_max_new = (r_sample > r_max) ? r_sample : r_max;

  // Published values follow RESULT: only a complete, error-free run updates them.
  always_ff @(posedge i_clk or negedge i_rn) begin
    if (!i_rn) begin
      r_min     <= '0;
      r_max     <= '0;
      r_min_dly <= '0;
      r_max_dly <= '0;
    end else if (r_state == ST_IDLE && i_start) begin
      r_min <= '1;
      r_max <= '0;
    end else if (r_state == ST_ACCUM) begin
      r_min <= w_min_new;
      r_max <= w_max_new;
      if (r_idx == LAST_IDX) begin
        r_min_dly <= w_min_new;
        r_max_dly <= w_max_new;
      end
    end
  end

  assign o_min_dly = r_min_dly;
  assign o_max_dly = r_max_dly;
`endif

endmodule

// File: tb/tb_inv_chain_delay_monitor.sv
// Directed bench for inv_chain_delay_monitor with behavioural chain models and a result scoreboard.
`timescale 1ns/1ps
module tb_inv_chain_delay_monitor;

  logic        clk = 1'b0;
  logic        rn = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic        ret0, ret1;
  logic        launch0, launch1, busy0, busy1, valid0, valid1, err0, err1;
  logic [11:0] result0, result1;
  wire         vdd, vss;
  assign vdd = 1'b1;
  assign vss = 1'b0;
`ifdef MON_MINMAX_EN
  logic [11:0] min0, max0, min1, max1;
`endif

  int checks = 0;
  int failures = 0;
  int sel = 0;
  int mode = 0;
  logic [11:0] sb_res[$];
  logic        sb_err[$];
  logic [5:1]  d0 = '0;
  logic [5:1]  d1 = '0;

  always #5 clk = ~clk;

  // Chain models: dut0 has an even chain, dut1 an odd chain with 5 cycles of delay.
  always @(posedge clk) begin
    d0 <= {d0[4:1], launch0};
    d1 <= {d1[4:1], launch1};
  end

  always_comb begin
    ret0 = 1'b0;
    case (mode)
      0: ret0 = launch0;
      1: ret0 = d0[3] | d0[5];
      default: ret0 = 1'b0;
    endcase
    ret1 = ~d1[5];
  end

  inv_chain_delay_monitor #(.CHAIN_INV(0)) dut0 (
    .i_clk(clk), .i_rn(rn), .io_vdd(vdd), .io_vss(vss), .i_start(start0), .i_ret(ret0),
    .o_launch(launch0), .o_busy(busy0), .o_valid(valid0), .o_err(err0), .o_result(result0)
`ifdef MON_MINMAX_EN
    , .o_min_dly(min0), .o_max_dly(max0)
`endif
  );

  inv_chain_delay_monitor #(.CHAIN_INV(1)) dut1 (
    .i_clk(clk), .i_rn(rn), .io_vdd(vdd), .io_vss(vss), .i_start(start1), .i_ret(ret1),
    .o_launch(launch1), .o_busy(busy1), .o_valid(valid1), .o_err(err1), .o_result(result1)
`ifdef MON_MINMAX_EN
    , .o_min_dly(min1), .o_max_dly(max1)
`endif
  );

  wire        m_launch = (sel != 0) ? launch1 : launch0;
  wire        m_busy   = (sel != 0) ? busy1 : busy0;
  wire        m_valid  = (sel != 0) ? valid1 : valid0;
  wire        m_err    = (sel != 0) ? err1 : err0;
  wire [11:0] m_result = (sel != 0) ? result1 : result0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel == 0) start0 = v;
    else start1 = v;
  endtask

  task automatic measure(input int s, input logic [11:0] exp_res, input logic exp_err,
                         input int exp_tog, input bit busy_pulse, input bit start_now,
                         input bit chk_hold, input logic [11:0] hold_res,
                         input bit start_in_done);
    int tog;
    logic prev;
    bit seen;
    logic [11:0] r;
    logic e;
    sel = s;
    sb_res.push_back(exp_res);
    sb_err.push_back(exp_err);
    if (!start_now) @(negedge clk);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    chk("busy_after_start", m_busy, 1);
    chk("err_clr_on_start", m_err, 0);
    tog = 0;
    prev = m_launch;
    seen = 0;
    for (int c = 0; c < 6000 && !seen; c++) begin
      @(negedge clk);
      if (m_launch !== prev) tog++;
      prev = m_launch;
      if (busy_pulse) set_start(c == 8);
      if (chk_hold && c == 6) chk("result_hold", m_result, hold_res);
      if (m_valid === 1'b1) seen = 1;
    end
    if (busy_pulse) set_start(1'b0);
    chk("valid_seen", seen, 1);
    if (seen) begin
      r = sb_res.pop_front();
      e = sb_err.pop_front();
      chk("result", m_result, r);
      chk("err", m_err, e);
      chk("busy_in_done", m_busy, 1);
      chk("launch_toggles", tog, exp_tog);
      if (start_in_done) set_start(1'b1);
      @(negedge clk);
      if (start_in_done) set_start(1'b0);
      chk("valid_one_cycle", m_valid, 0);
      chk("busy_cleared", m_busy, 0);
      chk("err_sticky", m_err, e);
      if (start_in_done) begin
        @(negedge clk);
        chk("start_in_done_ignored", m_busy, 0);
      end
    end else begin
      sb_res.delete();
      sb_err.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    logic prevl;
    int vcnt;

    #2 rn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_launch0", launch0, 0);
    chk("rst_busy0", busy0, 0);
    chk("rst_valid0", valid0, 0);
    chk("rst_err0", err0, 0);
    chk("rst_result0", result0, 0);
    chk("rst_launch1", launch1, 0);
    chk("rst_result1", result1, 0);
    rn = 1'b1;
    repeat (3) @(negedge clk);

    // Loopback: each sample equals the synchronizer depth.
    mode = 0;
    measure(0, 12'd2, 1'b0, 4, 0, 0, 0, 12'd0, 0);
    chk("loop_launch_end", launch0, 0);

    // Odd chain, 5 registered delays plus synchronizer.
    measure(1, 12'd7, 1'b0, 4, 0, 0, 0, 12'd0, 0);

    // Asymmetric rise 3 / fall 5 with a START pulse while busy.
    mode = 1;
    measure(0, 12'd6, 1'b0, 4, 1, 0, 0, 12'd0, 0);
`ifdef MON_MINMAX_EN
    chk("asym_min", min0, 5);
    chk("asym_max", max0, 7);
`endif

    // Back-to-back START in the cycle after VALID; old result holds until new DONE.
    mode = 0;
    measure(0, 12'd2, 1'b0, 4, 0, 1, 1, 12'd6, 1);

    // Stuck far end: first launch times out, result keeps its prior value.
    mode = 2;
    measure(0, 12'd2, 1'b1, 1, 0, 0, 0, 12'd0, 0);
    repeat (3) @(negedge clk);
    chk("err_held_idle", err0, 1);
`ifdef MON_MINMAX_EN
    chk("err_min_kept", min0, 2);
    chk("err_max_kept", max0, 2);
`endif

    // Next START clears ERR; chain starts settled at LAUNCH=1.
    mode = 0;
    measure(0, 12'd2, 1'b0, 4, 0, 0, 0, 12'd0, 0);
    chk("launch_end_odd_start", launch0, 1);

    // Reset during COUNT on dut1 after its rising launch.
    sel = 1;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    seen = 0;
    prevl = launch1;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (launch1 !== prevl) seen = 1;
    end
    chk("rst_test_toggle_seen", seen, 1);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_launch1", launch1, 1);
    rn = 1'b0;
    #1;
    chk("midrst_launch1", launch1, 0);
    chk("midrst_busy1", busy1, 0);
    chk("midrst_result1", result1, 0);
    @(negedge clk);
    rn = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (valid1 === 1'b1) vcnt++;
    end
    chk("no_valid_after_rst", vcnt, 0);
    chk("busy1_after_rst", busy1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
